// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register indices, CTRL bit positions and vector width shared by the interrupt controller
package irq_ctrl_pkg;
   localparam int VEC_W = 4;
   localparam logic [2:0] REG_PEND  = 3'd0;
   localparam logic [2:0] REG_ENA   = 3'd1;
   localparam logic [2:0] REG_SWSET = 3'd2;
   localparam logic [2:0] REG_CTRL  = 3'd3;
   localparam logic [2:0] REG_OVR   = 3'd4;
   localparam logic [2:0] REG_STAT  = 3'd5;
   localparam int CTRL_GIE = 0;
   localparam int CTRL_AGD = 1;
endpackage

// File: rtl/irq_prio.sv
// irq_prio: combinational highest-set-bit priority encoder, 16 requests to a 4-bit vector
//   req  in   16  request bits, bit 0 is never a source and is ignored
//   vec  out  4   index of the highest set bit, 0 when none
module irq_prio
   import irq_ctrl_pkg::*;
(
   input  logic [15:0]      req,
   output logic [VEC_W-1:0] vec
);
   always_comb begin
      vec = '0;
      for (int i = 1; i < 16; i++)
         if (req[i]) vec = VEC_W'(i);
   end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller with pending/enable/overrun registers and one registered irq/ivec
//   clk        in   clock, rising edge
//   p_reset_n  in   asynchronous active-low reset
//   src        in   NSRC strobes, src[i-1] requests vector i
//   io_sel/io_addr/io_wr/io_rd/io_din  register bus in, io_dout combinational read data
//   irq/ivec   out  registered request and highest enabled pending vector
//   iack       in   CPU accepted the vector on ivec
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int WIDTH    = 24,
   parameter int NSRC     = 15,
   parameter bit AUTO_GIE = 1'b1
) (
   input  logic             clk,
   input  logic             p_reset_n,
   input  logic [NSRC-1:0]  src,
   input  logic             io_sel,
   input  logic [2:0]       io_addr,
   input  logic             io_wr,
   input  logic             io_rd,
   input  logic [WIDTH-1:0] io_din,
   output logic [WIDTH-1:0] io_dout,
   output logic             irq,
   output logic [VEC_W-1:0] ivec,
   input  logic             iack
);
   // Register bit i belongs to vector i; bit 0 and bits above NSRC do not exist.
   localparam logic [15:0] VALID = 16'((32'h1 << (NSRC + 1)) - 32'h1) & ~16'h1;
   logic [15:0] pend, ena, ovr, src_v, din, set, clr, req, rd;
   logic [VEC_W-1:0] vec;
   logic gie, agd, wr, ack_ok, unused;
   assign unused = &{1'b0, io_rd, io_din[WIDTH-1:16]};
   assign src_v  = 16'({src, 1'b0});
   assign din    = io_din[15:0];
   assign wr     = io_sel & io_wr;
   assign ack_ok = iack & (ivec != '0);
   assign set    = src_v | ((wr && io_addr == REG_SWSET) ? din : '0);
   assign clr    = ((wr && io_addr == REG_PEND) ? din : '0) | (ack_ok ? 16'h1 << ivec : '0);
   assign req    = pend & ena;
   irq_prio u_prio (.req({req[15:1], 1'b0}), .vec(vec));
   always_ff @(posedge clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         pend <= '0;
         ena  <= '0;
         ovr  <= '0;
         gie  <= 1'b0;
         agd  <= AUTO_GIE;
         irq  <= 1'b0;
         ivec <= '0;
      end else begin
         // set beats clear so a strobe coinciding with its own clear is never lost
         pend <= ((pend & ~clr) | set) & VALID;
         // overrun only when the strobe lands on a bit that stays pending
         ovr  <= ((wr && io_addr == REG_OVR) ? ovr & ~din : ovr) | (src_v & pend & ~clr);
         if (wr && io_addr == REG_ENA) ena <= din & VALID;
         // a CPU write of CTRL overrides the auto-clear from iack
         if (wr && io_addr == REG_CTRL) begin
            gie <= din[CTRL_GIE];
            agd <= din[CTRL_AGD];
         end else if (ack_ok && agd) gie <= 1'b0;
         irq  <= gie & (|req);
         ivec <= vec;
      end
   end
   assign rd = io_addr == REG_PEND ? pend :
               io_addr == REG_ENA  ? ena :
               io_addr == REG_CTRL ? {14'd0, agd, gie} :
               io_addr == REG_OVR  ? ovr :
               io_addr == REG_STAT ? {11'd0, ivec, irq} : '0;
   assign io_dout = WIDTH'(rd);
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
   logic clk = 1'b0, p_reset_n = 1'b0;
   logic [14:0] src = '0;
   logic io_sel = 1'b0, io_wr = 1'b0, io_rd = 1'b0, iack = 1'b0;
   logic [2:0] io_addr = '0;
   logic [23:0] io_din = '0, io_dout, d;
   logic irq;
   logic [3:0] ivec;
   int n_cmp = 0, n_bad = 0;

   irq_ctrl dut (.clk(clk), .p_reset_n(p_reset_n), .src(src), .io_sel(io_sel), .io_addr(io_addr),
                 .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din), .io_dout(io_dout), .irq(irq),
                 .ivec(ivec), .iack(iack));

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [23:0] v);
      io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_din = v;
      cyc();
      io_sel = 1'b0; io_wr = 1'b0; io_din = '0;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [23:0] v);
      io_sel = 1'b1; io_rd = 1'b1; io_addr = a;
      #1 v = io_dout;
      io_sel = 1'b0; io_rd = 1'b0;
   endtask

   task automatic pulse(input logic [14:0] s);
      src = s;
      cyc();
      src = '0;
   endtask

   task automatic ack();
      iack = 1'b1;
      cyc();
      iack = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b want 0", irq); end
      n_cmp++; if (ivec !== 4'd0) begin n_bad++; $display("FAIL reset_ivec: got %0d want 0", ivec); end
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL reset_pend: got %h want 000000", d); end
      rd_reg(3'd1, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL reset_ena: got %h want 000000", d); end
      rd_reg(3'd4, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL reset_ovr: got %h want 000000", d); end
      rd_reg(3'd3, d);
      n_cmp++; if (d !== 24'h2) begin n_bad++; $display("FAIL reset_ctrl: got %h want 000002", d); end
   endtask

   task automatic test_basic();
      wr_reg(3'd1, 24'h0004);
      wr_reg(3'd3, 24'h3);
      pulse(15'h0002);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_latency: got %0b want 0", irq); end
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h4) begin n_bad++; $display("FAIL basic_pend: got %h want 000004", d); end
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd2) begin n_bad++; $display("FAIL basic_irq: got irq=%0b ivec=%0d want 1/2", irq, ivec); end
      rd_reg(3'd5, d);
      n_cmp++; if (d !== 24'h5) begin n_bad++; $display("FAIL basic_stat: got %h want 000005", d); end
      ack();
      cyc();
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_ack_irq: got %0b want 0", irq); end
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL basic_ack_pend: got %h want 000000", d); end
      rd_reg(3'd3, d);
      n_cmp++; if (d !== 24'h2) begin n_bad++; $display("FAIL basic_agd: got %h want 000002", d); end
   endtask

   task automatic test_priority();
      wr_reg(3'd1, 24'h7FFF);
      wr_reg(3'd3, 24'h1);
      pulse(15'h0104);
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd9) begin n_bad++; $display("FAIL prio_first: got irq=%0b ivec=%0d want 1/9", irq, ivec); end
      ack();
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd3) begin n_bad++; $display("FAIL prio_second: got irq=%0b ivec=%0d want 1/3", irq, ivec); end
      ack();
      cyc();
      n_cmp++; if (irq !== 1'b0 || ivec !== 4'd0) begin n_bad++; $display("FAIL prio_done: got irq=%0b ivec=%0d want 0/0", irq, ivec); end
   endtask

   task automatic test_overrun();
      pulse(15'h0010);
      cyc();
      n_cmp++; if (ivec !== 4'd5) begin n_bad++; $display("FAIL ovr_vec: got %0d want 5", ivec); end
      src = 15'h0010; iack = 1'b1;
      cyc();
      src = '0; iack = 1'b0;
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h20) begin n_bad++; $display("FAIL ovr_set_wins: got %h want 000020", d); end
      rd_reg(3'd4, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL ovr_clear_edge: got %h want 000000", d); end
      pulse(15'h0010);
      pulse(15'h0010);
      rd_reg(3'd4, d);
      n_cmp++; if (d !== 24'h20) begin n_bad++; $display("FAIL ovr_sticky: got %h want 000020", d); end
      wr_reg(3'd4, 24'h20);
      rd_reg(3'd4, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL ovr_w1c: got %h want 000000", d); end
      wr_reg(3'd0, 24'h20);
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL pend_w1c: got %h want 000000", d); end
   endtask

   task automatic test_swset();
      wr_reg(3'd3, 24'h2);
      wr_reg(3'd2, 24'h0100);
      cyc();
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h100) begin n_bad++; $display("FAIL sw_pend: got %h want 000100", d); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL sw_gie_off: got %0b want 0", irq); end
      rd_reg(3'd2, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL sw_read: got %h want 000000", d); end
      wr_reg(3'd3, 24'h3);
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd8) begin n_bad++; $display("FAIL sw_irq: got irq=%0b ivec=%0d want 1/8", irq, ivec); end
      io_sel = 1'b1; io_wr = 1'b1; io_addr = 3'd0; io_din = 24'h0100; src = 15'h0080;
      cyc();
      io_sel = 1'b0; io_wr = 1'b0; io_din = '0; src = '0;
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h100) begin n_bad++; $display("FAIL sw_set_over_w1c: got %h want 000100", d); end
      rd_reg(3'd4, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL sw_no_ovr: got %h want 000000", d); end
   endtask

   task automatic test_async_reset();
      pulse(15'h0003);
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd8) begin n_bad++; $display("FAIL ar_before: got irq=%0b ivec=%0d want 1/8", irq, ivec); end
      #2 p_reset_n = 1'b0;
      #1;
      n_cmp++; if (irq !== 1'b0 || ivec !== 4'd0) begin n_bad++; $display("FAIL ar_out: got irq=%0b ivec=%0d want 0/0", irq, ivec); end
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL ar_pend: got %h want 000000", d); end
      rd_reg(3'd1, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL ar_ena: got %h want 000000", d); end
      rd_reg(3'd3, d);
      n_cmp++; if (d !== 24'h2) begin n_bad++; $display("FAIL ar_ctrl: got %h want 000002", d); end
      cyc();
      p_reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_ack_vs_write();
      wr_reg(3'd1, 24'h0004);
      wr_reg(3'd3, 24'h3);
      pulse(15'h0002);
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd2) begin n_bad++; $display("FAIL avw_irq: got irq=%0b ivec=%0d want 1/2", irq, ivec); end
      io_sel = 1'b1; io_wr = 1'b1; io_addr = 3'd3; io_din = 24'h3; iack = 1'b1;
      cyc();
      io_sel = 1'b0; io_wr = 1'b0; io_din = '0; iack = 1'b0;
      rd_reg(3'd3, d);
      n_cmp++; if (d !== 24'h3) begin n_bad++; $display("FAIL avw_write_wins: got %h want 000003", d); end
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL avw_pend: got %h want 000000", d); end
      cyc();
      ack();
      rd_reg(3'd3, d);
      n_cmp++; if (d !== 24'h3) begin n_bad++; $display("FAIL ack_idle_ignored: got %h want 000003", d); end
   endtask

   task automatic test_mask_drop();
      wr_reg(3'd1, 24'h0008);
      wr_reg(3'd2, 24'h0008);
      cyc();
      n_cmp++; if (irq !== 1'b1 || ivec !== 4'd3) begin n_bad++; $display("FAIL mask_irq: got irq=%0b ivec=%0d want 1/3", irq, ivec); end
      wr_reg(3'd1, 24'h0);
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL mask_hold: got %0b want 1", irq); end
      cyc();
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mask_drop: got %0b want 0", irq); end
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h8) begin n_bad++; $display("FAIL mask_pend_kept: got %h want 000008", d); end
   endtask

   task automatic test_bounds();
      wr_reg(3'd6, 24'hFFFFFF);
      wr_reg(3'd7, 24'hFFFFFF);
      rd_reg(3'd6, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL addr6: got %h want 000000", d); end
      rd_reg(3'd7, d);
      n_cmp++; if (d !== 24'h0) begin n_bad++; $display("FAIL addr7: got %h want 000000", d); end
      wr_reg(3'd1, 24'hFFFFFF);
      rd_reg(3'd1, d);
      n_cmp++; if (d !== 24'h00FFFE) begin n_bad++; $display("FAIL ena_mask: got %h want 00FFFE", d); end
      wr_reg(3'd2, 24'hFFFFFF);
      rd_reg(3'd0, d);
      n_cmp++; if (d !== 24'h00FFFE) begin n_bad++; $display("FAIL pend_mask: got %h want 00FFFE", d); end
   endtask

   initial begin
      repeat (3) cyc();
      p_reset_n = 1'b1;
      cyc();
      test_reset();
      test_basic();
      test_priority();
      test_overrun();
      test_swset();
      test_async_reset();
      test_ack_vs_write();
      test_mask_drop();
      test_bounds();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
